dwrr_pkt_arb: RTL and testbench

Parametrised deficit-weighted round-robin arbiter with variable-length packets, the successor to the fixed-packet-size DWRR arbiter. Each requestor presents the length of its head packet. The arbiter grants whole packets while that requestor's deficit counter covers the length, then passes the turn to the next requestor that has work. It sits between per-flow input queues and a shared output link, and supplies the one-hot grant plus the granted index and length.

---
 rtl/dwrr_pkg.sv | 22 ++
 rtl/rr_pick.sv | 29 ++
 rtl/dwrr_pkt_arb.sv | 138 +++++++++++++
 tb/tb_dwrr_pkt_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dwrr_pkg.sv
// Shared types and helpers for the deficit-weighted round-robin packet arbiter.
package dwrr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } dwrr_state_t;

    // Widths are carried as 32 bits so one function serves any QWID up to 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

    function automatic logic [31:0] eff_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set bit of vec searching circularly from start.
module rr_pick #(
    parameter int NUM_REQS = 4,
    parameter int CNTWID   = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] vec,
    input  logic [CNTWID-1:0]   start,
    output logic                found,
    output logic [NUM_REQS-1:0] onehot,
    output logic [CNTWID-1:0]   idx
);

    always_comb begin : pick
        int p;
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        p      = 0;
        for (int j = 0; j < NUM_REQS; j++) begin
            p = (int'(start) + j) % NUM_REQS;
            if (!found && vec[p]) begin
                found     = 1'b1;
                onehot[p] = 1'b1;
                idx       = CNTWID'(p);
            end
        end
    end

endmodule

// File: rtl/dwrr_pkt_arb.sv
// Deficit-weighted round-robin arbiter for variable-length packets.
// Optional DWRR_SKIP_IDLE_EN: a finished turn hands straight to the next requestor.
module dwrr_pkt_arb
    import dwrr_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 10,
    parameter int LWID     = 8,
    parameter int CNTWID   = $clog2(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     blk,
    input  logic [NUM_REQS-1:0]      reqs,
    input  logic [NUM_REQS*QWID-1:0] input_quantums,
    input  logic [NUM_REQS*LWID-1:0] req_lens,
    output logic [NUM_REQS-1:0]      gnt,
    output logic [CNTWID-1:0]        gnt_idx,
    output logic [LWID-1:0]          gnt_len,
    output logic                     busy
);

    dwrr_state_t     state_q, state_d;
    logic [CNTWID-1:0] sel_q, sel_d;
    logic [CNTWID-1:0] rr_ptr_q, rr_ptr_d;
    logic [QWID-1:0]   def_q [NUM_REQS];
    logic [QWID-1:0]   def_d [NUM_REQS];

    logic [QWID-1:0]   quant [NUM_REQS];
    logic [LWID-1:0]   lens  [NUM_REQS];

    logic [LWID-1:0]     eff_l;
    logic                can_grant;
    logic                grant_now;
    logic [NUM_REQS-1:0] sel_mask;
    logic [NUM_REQS-1:0] pick_vec;
    logic [CNTWID-1:0]   pick_start;
    logic                pick_found;
    logic [NUM_REQS-1:0] pick_onehot;
    logic [CNTWID-1:0]   pick_idx;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            quant[i] = input_quantums[i*QWID +: QWID];
            lens[i]  = req_lens[i*LWID +: LWID];
        end
    end

    assign eff_l     = LWID'(eff_len(32'(lens[sel_q])));
    assign can_grant = (state_q == SERVE) && reqs[sel_q] &&
                       (def_q[sel_q] >= QWID'(eff_l));
    assign grant_now = can_grant && !blk && !rst;

    assign gnt     = grant_now ? (NUM_REQS'(1) << sel_q) : '0;
    assign gnt_len = grant_now ? eff_l : '0;
    assign gnt_idx = rst ? '0 : sel_q;
    assign busy    = (state_q == SERVE) && !rst;

    // In SERVE the current owner is masked so the skip-idle pick moves on.
    assign sel_mask   = (state_q == SERVE) ? (NUM_REQS'(1) << sel_q) : '0;
    assign pick_vec   = reqs & ~sel_mask;
    assign pick_start = (rr_ptr_q == CNTWID'(NUM_REQS-1)) ? '0 : rr_ptr_q + CNTWID'(1);

    rr_pick #(
        .NUM_REQS (NUM_REQS),
        .CNTWID   (CNTWID)
    ) u_pick (
        .vec    (pick_vec),
        .start  (pick_start),
        .found  (pick_found),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        def_d    = def_q;
        if (!blk) begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        sel_d    = pick_idx;
                        rr_ptr_d = pick_idx;
                        state_d  = SERVE;
                        for (int i = 0; i < NUM_REQS; i++) begin
                            if (pick_onehot[i])
                                def_d[i] = QWID'(sat_add(32'(def_q[i]), 32'(quant[i]),
                                                         32'({QWID{1'b1}})));
                        end
                    end
                end
                SERVE: begin
                    if (can_grant) begin
                        def_d[sel_q] = def_q[sel_q] - QWID'(eff_l);
                    end else begin
                        if (!reqs[sel_q])
                            def_d[sel_q] = '0;
`ifdef DWRR_SKIP_IDLE_EN
                        if (pick_found) begin
                            sel_d    = pick_idx;
                            rr_ptr_d = pick_idx;
                            for (int i = 0; i < NUM_REQS; i++) begin
                                if (pick_onehot[i])
                                    def_d[i] = QWID'(sat_add(32'(def_q[i]), 32'(quant[i]),
                                                             32'({QWID{1'b1}})));
                            end
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= CNTWID'(NUM_REQS-1);
            for (int i = 0; i < NUM_REQS; i++)
                def_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_REQS; i++)
                def_q[i] <= def_d[i];
        end
    end

endmodule

// File: tb/tb_dwrr_pkt_arb.sv
// Directed bench for dwrr_pkt_arb: per-cycle expected outputs queued by the stimulus.
module tb_dwrr_pkt_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        blk = 1'b0;
    logic [3:0]  reqs = '0;
    logic [39:0] q_vec = '0;
    logic [31:0] l_vec = '0;
    logic [3:0]  gnt;
    logic [1:0]  gnt_idx;
    logic [7:0]  gnt_len;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] g;
        logic [1:0] i;
        logic [7:0] l;
        logic       b;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dwrr_pkt_arb #(
        .NUM_REQS (4),
        .QWID     (10),
        .LWID     (8),
        .CNTWID   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .blk            (blk),
        .reqs           (reqs),
        .input_quantums (q_vec),
        .req_lens       (l_vec),
        .gnt            (gnt),
        .gnt_idx        (gnt_idx),
        .gnt_len        (gnt_len),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("gnt", 32'(gnt), 32'(e.g));
            chk("busy", 32'(busy), 32'(e.b));
            if (e.b) chk("gnt_idx", 32'(gnt_idx), 32'(e.i));
            if (e.g != 4'd0) chk("gnt_len", 32'(gnt_len), 32'(e.l));
        end
    end

    task automatic step(input logic [3:0] g, input int i, input int l, input logic b);
        exp_t e;
        e.g = g;
        e.i = 2'(i);
        e.l = 8'(l);
        e.b = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic gr(input int i, input int l, input int n);
        for (int k = 0; k < n; k++) step(4'(1 << i), i, l, 1'b1);
    endtask

    task automatic dn(input int i);
        step(4'd0, i, 0, 1'b1);
    endtask

    task automatic id();
        step(4'd0, 0, 0, 1'b0);
    endtask

    task automatic set_q(input int i, input int v);
        q_vec[i*10 +: 10] = 10'(v);
    endtask

    task automatic set_l(input int i, input int v);
        l_vec[i*8 +: 8] = 8'(v);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        blk  = 1'b0;
        reqs = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        chk("rst_len", 32'(gnt_len), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // single requestor: 20 credit, 8-byte packets -> 2 grants, 4 carried, then 3
        do_reset();
        set_q(0, 20); set_l(0, 8);
        reqs = 4'b0001;
        id();
        gr(0, 8, 2);
        dn(0);
        id();
        gr(0, 8, 3);
        reqs = 4'b0000;
        dn(0);
        id();

        // fairness and turn order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) set_q(i, 16);
        set_l(0, 16); set_l(1, 4); set_l(2, 8); set_l(3, 16);
        reqs = 4'b1111;
        id();
        gr(0, 16, 1);
`ifdef DWRR_SKIP_IDLE_EN
        dn(0); gr(1, 4, 4);
        dn(1); gr(2, 8, 2);
        dn(2); gr(3, 16, 1);
        dn(3); gr(0, 16, 1);
`else
        dn(0); id(); gr(1, 4, 4);
        dn(1); id(); gr(2, 8, 2);
        dn(2); id(); gr(3, 16, 1);
        dn(3); id(); gr(0, 16, 1);
`endif
        reqs = 4'b0000;
        dn(0);
        id();

        // empty forfeit: requestor 2 leaves with 12 credit, which must be lost
        do_reset();
        set_q(2, 20); set_l(2, 4);
        set_q(3, 4);  set_l(3, 4);
        reqs = 4'b1100;
        id();
        gr(2, 4, 2);
        reqs = 4'b1000;
        dn(2);
`ifndef DWRR_SKIP_IDLE_EN
        id();
`endif
        gr(3, 4, 1);
        reqs = 4'b0100;
        dn(3);
`ifndef DWRR_SKIP_IDLE_EN
        id();
`endif
        gr(2, 4, 5);
        reqs = 4'b0000;
        dn(2);
        id();

        // saturation at 1023, zero length, zero quantum
        do_reset();
        set_q(1, 1023); set_l(1, 255);
        reqs = 4'b0010;
        id();
        gr(1, 255, 4);
        dn(1);
        id();
        gr(1, 255, 4);
        dn(1);
        set_q(1, 0); set_l(1, 0);
        id();
        gr(1, 1, 3);
        dn(1);
        id();
        dn(1);
        reqs = 4'b0000;
        id();

        // stall mid-turn and in IDLE, then reset mid-train
        do_reset();
        set_q(0, 40); set_l(0, 8);
        reqs = 4'b0001;
        id();
        gr(0, 8, 2);
        blk = 1'b1;
        dn(0); dn(0); dn(0);
        blk = 1'b0;
        gr(0, 8, 3);
        dn(0);
        blk = 1'b1;
        id();
        blk = 1'b0;
        id();
        gr(0, 8, 2);
        rst = 1'b1;
        blk = 1'b1;
        begin
            exp_t e;
            e.g = 4'd0; e.i = 2'd0; e.l = 8'd0; e.b = 1'b0;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("midrst_idx", 32'(gnt_idx), 32'd0);
        chk("midrst_len", 32'(gnt_len), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        blk = 1'b0;
        set_q(1, 0); set_l(1, 5);
        reqs = 4'b0011;
        id();
        gr(0, 8, 5);
        reqs = 4'b0000;
        dn(0);
        id();

        // turn gap between requestors 0 and 2
        do_reset();
        set_q(0, 8); set_l(0, 8);
        set_q(2, 8); set_l(2, 8);
        reqs = 4'b0101;
        id();
        gr(0, 8, 1);
        dn(0);
`ifndef DWRR_SKIP_IDLE_EN
        id();
`endif
        gr(2, 8, 1);
        reqs = 4'b0000;
        dn(2);
        id();

        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
